nt_node_activity_monitor: RTL
=============================

Name: nt_node_activity_monitor

Overview:
- Downstream observation stage for a Nt-node subcircuit output (e.g. net I3560). Samples the single-bit node output in the same clock domain.
- Accumulates per-window activity statistics: count of ones and count of toggles.
- Flags rare-trigger and stuck-at behaviour, the signatures trojan detection looks for.
- Hands each window's result out over a valid/ready report interface.

Parameters:
- WINDOW, 200, cycles per observation window; legal range 2..2^CNT_W-1.
- CNT_W, 8, width of the ones and toggle counters; must satisfy WINDOW < 2^CNT_W, so counters never overflow.
- RARE_THR, 4, rarity threshold; legal range 1..WINDOW/2.

Ports:
- I1294_clk  in  1  single clock, rising edge.
- I1301_rst  in  1  asynchronous reset, active-high.
- mon_en  in  1  monitor enable.
- sig_in  in  1  observed node output.
- rpt_ready  in  1  consumer accepts the report.
- rpt_valid  out  1  report available.
- rpt_ones  out  CNT_W  number of cycles the sample was 1 in the window.
- rpt_toggles  out  CNT_W  number of sample transitions in the window.
- rpt_rare  out  1  rare-value flag.
- rpt_stuck  out  1  no-activity flag.
- rpt_ovf  out  1  sticky: a window result was dropped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: while I1301_rst=1, state=IDLE and all internal registers and outputs are 0, applied immediately without waiting for a clock edge.
- Input pipeline:
  - s_q <= sig_in on every edge.
  - s_p <= s_q on every edge, in every state.
  - toggle = s_q ^ s_p.
- FSM states: IDLE, ARM, COUNT, CLOSE.
- IDLE:
  - Go to ARM when mon_en=1.
- ARM (1 cycle):
  - ones=0, toggles=0, wcnt=WINDOW-1.
  - Go to COUNT.
- COUNT (exactly WINDOW cycles):
  - Each cycle, ones += s_q and toggles += toggle.
  - Go to CLOSE when wcnt=0, otherwise decrement wcnt.
- CLOSE (1 cycle, no accumulation):
  - Compute result from the final counters.
  - Clear the counters and reload wcnt=WINDOW-1.
  - Go to COUNT if mon_en=1, else IDLE.
  - Steady-state report period is WINDOW+1 cycles.
- mon_en=0 observed in ARM or COUNT:
  - Go to IDLE on the next edge.
  - The partial window is discarded and no report is produced.
  - An already pending report is unaffected.
- Result flags:
  - rpt_stuck = (toggles==0).
  - rpt_rare = (0<ones<RARE_THR) or (0<WINDOW-ones<RARE_THR).
  - A constant window (ones=0 or ones=WINDOW) is stuck, not rare.
- Report handshake:
  - Data is latched into the report registers at the CLOSE edge; rpt_valid=1 from the next cycle.
  - rpt_valid and all rpt_* data stay stable until a cycle with rpt_valid & rpt_ready; rpt_valid clears after that edge.
  - At CLOSE with rpt_valid=1 and rpt_ready=1 in the same cycle: the old report is consumed, the new one is loaded, and rpt_valid stays 1.
  - At CLOSE with rpt_valid=1 and rpt_ready=0: the new result is dropped, the old one is kept, and rpt_ovf is set.
  - rpt_ovf clears only on reset.
- Latency (mon_en high, edge E0 sees it):
  - ARM after E0, COUNT after E1..E16 for WINDOW=16.
  - CLOSE after E17.
  - rpt_valid=1 after E18.

Test Plan (WINDOW=16, CNT_W=8, RARE_THR=4, rpt_ready=1 unless stated):
1. sig_in held 0, mon_en rises before E0 -> rpt_valid=1 after E18; ones=0, toggles=0, stuck=1, rare=0; next report after E35.
2. sig_in alternating 0/1 every cycle -> ones=8, toggles=16, stuck=0, rare=0.
3. sig_in=1 for one cycle in mid-window, else 0 -> ones=1, toggles=2, rare=1, stuck=0.
4. sig_in=1 for all but two cycles of the window, starting at 1 in the prior cycle -> ones=14, rare=1, toggles=2.
5. rpt_ready=0 across two windows -> first report held stable, second dropped, rpt_ovf=1; on rpt_ready=1 the first window's data is delivered and rpt_ovf stays 1.
6. mon_en dropped during the 5th COUNT cycle -> IDLE next edge, busy=0, no rpt_valid.
7. I1301_rst pulsed between edges mid-COUNT -> all outputs 0 immediately; after release the FSM is in IDLE.

Source files
------------

// File: rtl/nt_node_activity_monitor.sv
// Activity monitor for a single-bit Nt-node output: per-window ones/toggle counts,
// rare-value and stuck-at flags, delivered over a valid/ready report port.
module nt_node_activity_monitor #(
    parameter int WINDOW   = 200,
    parameter int CNT_W    = 8,
    parameter int RARE_THR = 4
) (
    input  logic             I1294_clk,
    input  logic             I1301_rst,
    input  logic             mon_en,
    input  logic             sig_in,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_ones,
    output logic [CNT_W-1:0] rpt_toggles,
    output logic             rpt_rare,
    output logic             rpt_stuck,
    output logic             rpt_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        CLOSE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] WLAST  = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] THR_C  = CNT_W'(RARE_THR);
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

    state_t           state_q, state_d;
    logic             s_q, s_p;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] tog_q, tog_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] r_ones_q, r_ones_d;
    logic [CNT_W-1:0] r_tog_q, r_tog_d;
    logic             r_rare_q, r_rare_d;
    logic             r_stuck_q, r_stuck_d;
    logic             ovf_q, ovf_d;

    logic             toggle_s;
    logic             res_stuck_s;
    logic             res_rare_s;

    // Window FSM, counters and report register next-state logic
    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        tog_d     = tog_q;
        wcnt_d    = wcnt_q;
        valid_d   = valid_q;
        r_ones_d  = r_ones_q;
        r_tog_d   = r_tog_q;
        r_rare_d  = r_rare_q;
        r_stuck_d = r_stuck_q;
        ovf_d     = ovf_q;

        toggle_s    = s_q ^ s_p;
        res_stuck_s = (tog_q == ZERO_C);
        // A constant window (0 or WINDOW ones) is stuck, never rare
        res_rare_s  = ((ones_q != ZERO_C) && (ones_q < THR_C)) ||
                      ((ones_q != WIN_C) && ((WIN_C - ones_q) < THR_C));

        if (valid_q && rpt_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            IDLE: begin
                if (mon_en) begin
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                ones_d = ZERO_C;
                tog_d  = ZERO_C;
                wcnt_d = WLAST;
                if (mon_en) begin
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                if (!mon_en) begin
                    state_d = IDLE;
                end else begin
                    ones_d = ones_q + {{(CNT_W-1){1'b0}}, s_q};
                    tog_d  = tog_q + {{(CNT_W-1){1'b0}}, toggle_s};
                    if (wcnt_q == ZERO_C) begin
                        state_d = CLOSE;
                    end else begin
                        wcnt_d = wcnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            CLOSE: begin
                // Same-cycle consume of an old report frees the slot for the new one
                if (!valid_q || rpt_ready) begin
                    valid_d   = 1'b1;
                    r_ones_d  = ones_q;
                    r_tog_d   = tog_q;
                    r_rare_d  = res_rare_s;
                    r_stuck_d = res_stuck_s;
                end else begin
                    ovf_d = 1'b1;
                end
                ones_d = ZERO_C;
                tog_d  = ZERO_C;
                wcnt_d = WLAST;
                if (mon_en) begin
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, input pipeline and report registers
    always_ff @(posedge I1294_clk or posedge I1301_rst) begin
        if (I1301_rst) begin
            state_q   <= IDLE;
            s_q       <= 1'b0;
            s_p       <= 1'b0;
            ones_q    <= ZERO_C;
            tog_q     <= ZERO_C;
            wcnt_q    <= ZERO_C;
            valid_q   <= 1'b0;
            r_ones_q  <= ZERO_C;
            r_tog_q   <= ZERO_C;
            r_rare_q  <= 1'b0;
            r_stuck_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= sig_in;
            s_p       <= s_q;
            ones_q    <= ones_d;
            tog_q     <= tog_d;
            wcnt_q    <= wcnt_d;
            valid_q   <= valid_d;
            r_ones_q  <= r_ones_d;
            r_tog_q   <= r_tog_d;
            r_rare_q  <= r_rare_d;
            r_stuck_q <= r_stuck_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rpt_valid   = valid_q;
    assign rpt_ones    = r_ones_q;
    assign rpt_toggles = r_tog_q;
    assign rpt_rare    = r_rare_q;
    assign rpt_stuck   = r_stuck_q;
    assign rpt_ovf     = ovf_q;
    assign busy        = (state_q != IDLE);

endmodule
